// File: rtl/fp8_div_seq.sv
// fp8_div_seq: sequential FP8 (1/4/3) divider computing a_in / b_in.
// The mantissa quotient comes from an iterative restoring division, one
// quotient bit per cycle. Zero operands short-circuit straight to DONE.
module fp8_div_seq #(
  parameter int EXP_BITS      = 4,
  parameter int MANTISSA_BITS = 3,
  parameter int BIAS          = (1 << (EXP_BITS - 1)) - 1
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [EXP_BITS+MANTISSA_BITS:0]   a_in,
  input  logic [EXP_BITS+MANTISSA_BITS:0]   b_in,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [EXP_BITS+MANTISSA_BITS:0]   q_out,
  output logic [2:0]                        flags
);

  localparam int W  = 1 + EXP_BITS + MANTISSA_BITS;  // word width
  localparam int MW = MANTISSA_BITS + 1;             // significand width with hidden bit
  localparam int QW = MANTISSA_BITS + 2;             // quotient bits produced
  localparam int EW = EXP_BITS + 2;                  // signed working exponent width
  localparam int CW = $clog2(QW + 1);                // step counter width

  localparam logic signed [EW-1:0] BIAS_S = EW'(BIAS);
  localparam logic signed [EW-1:0] ONE_S  = EW'(1);
  localparam logic signed [EW-1:0] EMAX_S = EW'((1 << EXP_BITS) - 1);

  typedef enum logic [1:0] {IDLE, DIV, NORM, DONE} state_t;

  state_t                  state_q, state_d;
  logic                    s_q;
  logic [MW:0]             rem_q;
  logic [MW-1:0]           div_q;
  logic [QW-1:0]           qd_q;
  logic signed [EW-1:0]    e_q;
  logic [CW-1:0]           cnt_q;
  logic [W-1:0]            res_q;
  logic [2:0]              flags_q;

  // Operand fields
  logic                    sa, sb;
  logic [EXP_BITS-1:0]     ea, eb;
  logic [MANTISSA_BITS-1:0] ma, mb;
  logic signed [EW-1:0]    e_raw;

  assign sa = a_in[W-1];
  assign sb = b_in[W-1];
  assign ea = a_in[W-2 -: EXP_BITS];
  assign eb = b_in[W-2 -: EXP_BITS];
  assign ma = a_in[MANTISSA_BITS-1:0];
  assign mb = b_in[MANTISSA_BITS-1:0];
  assign e_raw = $signed({2'b00, ea}) - $signed({2'b00, eb}) + BIAS_S;

  // Saturating pack of sign/exponent/mantissa into {flags, word}
  function automatic logic [W+2:0] pack_result(input logic                     s,
                                                input logic signed [EW-1:0]   e,
                                                input logic [MANTISSA_BITS-1:0] m);
    if (e > EMAX_S)
      pack_result = {3'b010, s, {(W-1){1'b1}}};
    else if (e < ONE_S)
      pack_result = {3'b001, s, {(W-1){1'b0}}};
    else
      pack_result = {3'b000, s, e[EXP_BITS-1:0], m};
  endfunction

  // One restoring step: subtract when the partial remainder covers the divisor
  logic [MW:0]             div_ext, rem_sub, rem_nxt;
  logic                    qbit;

  assign div_ext = {1'b0, div_q};
  assign qbit    = (rem_q >= div_ext);
  assign rem_sub = qbit ? (rem_q - div_ext) : rem_q;
  assign rem_nxt = rem_sub << 1;

  // Normalisation: a quotient below 16 needs one extra left shift
  logic [MANTISSA_BITS-1:0] m_n;
  logic signed [EW-1:0]     e_n;

  assign m_n = qd_q[QW-1] ? qd_q[QW-2:1] : qd_q[QW-3:0];
  assign e_n = qd_q[QW-1] ? e_q : (e_q - ONE_S);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (in_valid) state_d = ((eb == '0) || (ea == '0)) ? DONE : DIV;
      DIV:  if (cnt_q == CW'(QW - 1)) state_d = NORM;
      NORM: state_d = DONE;
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    q_out     = res_q;
    flags     = flags_q;
  end

  // Datapath: operand capture, division steps, result packing
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_q     <= 1'b0;
      rem_q   <= '0;
      div_q   <= '0;
      qd_q    <= '0;
      e_q     <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
      flags_q <= '0;
    end else begin
      case (state_q)
        IDLE: if (in_valid) begin
          s_q   <= sa ^ sb;
          rem_q <= {1'b0, 1'b1, ma};
          div_q <= {1'b1, mb};
          qd_q  <= '0;
          e_q   <= e_raw;
          cnt_q <= '0;
          if (eb == '0) begin
            res_q   <= {sa ^ sb, {(W-1){1'b1}}};
            flags_q <= 3'b100;
          end else if (ea == '0) begin
            res_q   <= {sa ^ sb, {(W-1){1'b0}}};
            flags_q <= 3'b000;
          end
        end
        DIV: begin
          rem_q <= rem_nxt;
          qd_q  <= {qd_q[QW-2:0], qbit};
          cnt_q <= cnt_q + CW'(1);
        end
        NORM: {flags_q, res_q} <= pack_result(s_q, e_n, m_n);
        default: ;
      endcase
    end
  end

endmodule
